vc_xbus_bridge: RTL

Parametrised byte-serial external-memory bridge between the vc CPU's split read/write request ports and a narrow 8-bit pin bus. It is the successor of the current 16-bit-only sequencer:
- generalised to RV=16/32 with any byte-lane mask on reads and writes;
- configurable address width on the pins;
- configurable read wait states;
- an optional posted-write buffer.

The TT top-level instantiates it and maps its strobes onto uio_out.

---
 rtl/vc_xbus_pkg.sv | 28 ++
 rtl/vc_xbus_post_buf.sv | 42 ++++
 rtl/vc_xbus_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vc_xbus_pkg.sv
// Shared types and helpers for the vc byte-serial memory bridge.
// Combinational only; no flow control.
package vc_xbus_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam int MAX_NL = 4;

    function automatic int nl_of(input int rv);
        return rv / 8;
    endfunction

    function automatic int lb_of(input int rv);
        return (rv == 16) ? 1 : 2;
    endfunction

    // Lowest set lane at or above cur; 4 means no lane left.
    function automatic logic [2:0] next_lane(input logic [MAX_NL-1:0] mask, input logic [2:0] cur);
        logic [2:0] res;
        res = 3'd4;
        for (int i = MAX_NL - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= cur))
                res = 3'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/vc_xbus_post_buf.sv
// One-entry posted-write holding register; loads in 1 cycle, load beats clear.
// No backpressure: the bridge only loads it when it is free or draining.
module vc_xbus_post_buf
    import vc_xbus_pkg::*;
#(
    parameter int AW = 16,
    parameter int NL = 4,
    parameter int RV = 32
) (
    input  logic          clk,
    input  logic          r_reset,
    input  logic          ena,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] in_abytes,
    input  logic [NL-1:0] in_mask,
    input  logic [RV-1:0] in_data,
    output logic [AW-1:0] abytes,
    output logic [NL-1:0] mask,
    output logic [RV-1:0] data,
    output logic          vld
);

    always_ff @(posedge clk) begin
        if (r_reset) begin
            abytes <= '0;
            mask   <= '0;
            data   <= '0;
            vld    <= 1'b0;
        end else if (ena) begin
            if (load) begin
                abytes <= in_abytes;
                mask   <= in_mask;
                data   <= in_data;
                vld    <= 1'b1;
            end else if (clear) begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vc_xbus_bridge.sv
// Byte-serial CPU-to-pin-bus bridge; latency ADDR_BYTES + k*(1 or 1+WAIT) + 1 cycles after accept.
// Requests wait (held by CPU) until IDLE; optional posted writes under VC_XBUS_POST_EN.
module vc_xbus_bridge
    import vc_xbus_pkg::*;
#(
    parameter int RV = 32,
    parameter int ADDR_BYTES = 2,
    parameter int WAIT = 0,
    localparam int NL = nl_of(RV),
    localparam int LB = lb_of(RV)
) (
    input  logic                  clk,
    input  logic                  r_reset,
    input  logic                  ena,
    input  logic [RV-1:LB]        raddr,
    input  logic [NL-1:0]         rmask,
    output logic [RV-1:0]         rdata,
    output logic                  rdone,
    input  logic [RV-1:LB]        waddr,
    input  logic [NL-1:0]         wmask,
    input  logic [RV-1:0]         wdata,
    output logic                  wdone,
    output logic [7:0]            bus_out,
    input  logic [7:0]            bus_in,
    output logic [ADDR_BYTES-1:0] lat,
    output logic                  wr,
    output logic                  rd,
    output logic [LB-1:0]         lane
);

    localparam int AW = ADDR_BYTES * 8;
    localparam logic [ADDR_BYTES-1:0] LAT_ONE = {{(ADDR_BYTES-1){1'b0}}, 1'b1};

    function automatic logic [AW-1:0] ext_addr(input logic [RV-1:LB] a);
        logic [RV+23:0] t;
        t = {24'b0, a, {LB{1'b0}}};
        return t[AW-1:0];
    endfunction

    state_t          state, n_state;
    logic [1:0]      ab_idx, n_ab_idx;
    logic [LB-1:0]   cur_lane, n_cur_lane;
    logic [2:0]      wcnt, n_wcnt;
    logic            q_wr, n_q_wr;
    logic [AW-1:0]   q_abytes;
    logic [NL-1:0]   q_mask;
    logic [RV-1:0]   q_data;

    logic [7:0]            n_bus_out;
    logic [ADDR_BYTES-1:0] n_lat;
    logic                  n_wr, n_rd, n_rdone, n_wdone;
    logic [LB-1:0]         n_lane;
    logic [RV-1:0]         n_rdata;

    logic            acc_ok, sel_wr, acc, q_load;
    logic [AW-1:0]   in_abytes;
    logic [AW-1:0]   act_abytes;
    logic [NL-1:0]   act_mask;
    logic [RV-1:0]   act_data;
    logic [MAX_NL-1:0] mask4;
    logic [2:0]      first_ln, nxt_ln;

    assign sel_wr    = |wmask;
    assign acc       = acc_ok && (sel_wr || (|rmask));
    assign in_abytes = ext_addr(sel_wr ? waddr : raddr);

`ifdef VC_XBUS_POST_EN
    logic [AW-1:0] b_abytes;
    logic [NL-1:0] b_mask;
    logic [RV-1:0] b_data;
    logic          buf_vld;

    // A posted write's DONE doubles as the drain point, so the next request goes straight to ADDR.
    assign acc_ok = (state == IDLE) || ((state == DONE) && buf_vld);
    assign q_load = acc && !sel_wr;

    vc_xbus_post_buf #(.AW(AW), .NL(NL), .RV(RV)) u_post_buf (
        .clk       (clk),
        .r_reset   (r_reset),
        .ena       (ena),
        .load      (acc && sel_wr),
        .clear     (state == DONE),
        .in_abytes (in_abytes),
        .in_mask   (wmask),
        .in_data   (wdata),
        .abytes    (b_abytes),
        .mask      (b_mask),
        .data      (b_data),
        .vld       (buf_vld)
    );

    assign act_abytes = q_wr ? b_abytes : q_abytes;
    assign act_mask   = q_wr ? b_mask   : q_mask;
    assign act_data   = q_wr ? b_data   : q_data;
`else
    assign acc_ok     = (state == IDLE);
    assign q_load     = acc;
    assign act_abytes = q_abytes;
    assign act_mask   = q_mask;
    assign act_data   = q_data;
`endif

    assign mask4    = MAX_NL'(act_mask);
    assign first_ln = next_lane(mask4, 3'd0);
    assign nxt_ln   = next_lane(mask4, 3'(cur_lane) + 3'd1);

    // Outputs are computed for the next cycle and registered alongside the state.
    always_comb begin
        n_state    = state;
        n_ab_idx   = ab_idx;
        n_cur_lane = cur_lane;
        n_wcnt     = wcnt;
        n_q_wr     = q_wr;
        n_bus_out  = 8'h00;
        n_lat      = '0;
        n_wr       = 1'b0;
        n_rd       = 1'b0;
        n_lane     = '0;
        n_rdone    = 1'b0;
        n_wdone    = 1'b0;
        n_rdata    = rdata;
        if (acc) begin
            n_state   = ADDR;
            n_q_wr    = sel_wr;
            n_ab_idx  = 2'(ADDR_BYTES - 1);
            n_bus_out = in_abytes[AW-1 -: 8];
            n_lat     = LAT_ONE << (ADDR_BYTES - 1);
            if (!sel_wr)
                n_rdata = '0;
`ifdef VC_XBUS_POST_EN
            n_wdone = sel_wr;
`endif
        end else begin
            case (state)
                ADDR: begin
                    if (ab_idx == 2'd0) begin
                        n_state    = DATA;
                        n_cur_lane = first_ln[LB-1:0];
                        n_lane     = first_ln[LB-1:0];
                        n_wcnt     = 3'd0;
                        n_wr       = q_wr;
                        n_rd       = !q_wr;
                        n_bus_out  = q_wr ? act_data[8*int'(first_ln) +: 8] : 8'h00;
                    end else begin
                        n_ab_idx  = ab_idx - 2'd1;
                        n_bus_out = act_abytes[8*int'(n_ab_idx) +: 8];
                        n_lat     = LAT_ONE << n_ab_idx;
                    end
                end
                DATA: begin
                    if (q_wr || (wcnt == 3'(WAIT))) begin
                        if (!q_wr)
                            n_rdata[8*int'(cur_lane) +: 8] = bus_in;
                        if (nxt_ln[2]) begin
                            n_state = DONE;
                            n_rdone = !q_wr;
`ifndef VC_XBUS_POST_EN
                            n_wdone = q_wr;
`endif
                        end else begin
                            n_cur_lane = nxt_ln[LB-1:0];
                            n_lane     = nxt_ln[LB-1:0];
                            n_wcnt     = 3'd0;
                            n_wr       = q_wr;
                            n_rd       = !q_wr;
                            n_bus_out  = q_wr ? act_data[8*int'(nxt_ln) +: 8] : 8'h00;
                        end
                    end else begin
                        n_wcnt = wcnt + 3'd1;
                        n_rd   = 1'b1;
                        n_lane = cur_lane;
                    end
                end
                DONE:    n_state = IDLE;
                default: n_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            state    <= IDLE;
            ab_idx   <= 2'd0;
            cur_lane <= '0;
            wcnt     <= 3'd0;
            q_wr     <= 1'b0;
            q_abytes <= '0;
            q_mask   <= '0;
            q_data   <= '0;
            bus_out  <= 8'h00;
            lat      <= '0;
            wr       <= 1'b0;
            rd       <= 1'b0;
            lane     <= '0;
            rdone    <= 1'b0;
            wdone    <= 1'b0;
            rdata    <= '0;
        end else if (ena) begin
            state    <= n_state;
            ab_idx   <= n_ab_idx;
            cur_lane <= n_cur_lane;
            wcnt     <= n_wcnt;
            q_wr     <= n_q_wr;
            bus_out  <= n_bus_out;
            lat      <= n_lat;
            wr       <= n_wr;
            rd       <= n_rd;
            lane     <= n_lane;
            rdone    <= n_rdone;
            wdone    <= n_wdone;
            rdata    <= n_rdata;
            if (q_load) begin
                q_abytes <= in_abytes;
                q_mask   <= sel_wr ? wmask : rmask;
                q_data   <= wdata;
            end
        end
    end

endmodule
